cp0: RTL and testbench
======================

# cp0

Coprocessor-0 exception/interrupt controller for the pipelined MIPS core. It sits beside the M stage and consumes the external `interrupt` line and peripheral interrupt lines as `hw_int`. It decides whether the M-stage instruction is the victim of an interrupt or exception, and records SR/Cause/EPC. It serves `mfc0`, `mtc0` and `eret` for the handler at 0x0000_4180.

## Interface
Parameters:
- `PRID_VAL`, 32'h4D49_5053: read-only value of PRId (reg 15).
- `HANDLER_PC`, 32'h0000_4180: exception entry. Not used internally; exported for the PC mux.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `en` in 1: `mtc0` write strobe, M stage.
- `cp0_addr` in 5: CP0 register number (`rd` field).
- `cp0_wdata` in 32: `mtc0` data.
- `cp0_rdata` out 32: `mfc0` data, combinational.
- `vpc` in 32: PC of the M-stage instruction (macroscopic PC).
- `bd_in` in 1: the M-stage instruction is in a delay slot.
- `exc_code_in` in 5: synchronous exception code of the M-stage instruction; 0 = none.
- `exl_clr` in 1: `eret` is in M.
- `hw_int` in 6: interrupt lines, mapped to IP[15:10]. Bit 2 is the external `interrupt`.
- `req` out 1: flush the pipeline and redirect to `HANDLER_PC` this cycle. Combinational.
- `epc_out` out 32: current EPC, the `eret` target.

## Operation
- Registers:
  - SR (12): IM[15:10], EXL[1], IE[0]. All other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]. All other bits read 0.
  - EPC (14): 32 bits.
  - PRId (15): `PRID_VAL`.
- `int_req = IE & ~EXL & |(hw_int & IM)`. Uses live `hw_int`, not the latched IP.
- `exc_req = ~EXL & (exc_code_in != 0)`.
- `req = (int_req | exc_req) & ~reset`.
- On a rising edge with `req`:
  - EXL <= 1.
  - BD <= `bd_in`.
  - ExcCode <= `int_req` ? 0 : `exc_code_in`. Interrupt beats exception.
  - EPC <= `bd_in` ? `vpc` − 4 : `vpc`. 32-bit wrap; no alignment applied.
- Every edge: Cause.IP <= `hw_int`, regardless of other activity.
- `mtc0` (`en` & ~`req`):
  - addr 12 writes SR masked to bits 15:10, 1, 0.
  - addr 14 writes EPC.
  - Writes to 13, 15 and any other address are ignored.
- `exl_clr` & ~`req`: EXL <= 0.
- Same-edge priority: `req` > `exl_clr` > `mtc0`.
  - A `req` suppresses a coincident `mtc0` and `exl_clr`.
  - An `exl_clr` coincident with an `mtc0` to SR: the `mtc0` data is applied, then EXL is forced to 0.
- `cp0_rdata`: register selected by `cp0_addr`; 0 for unmapped addresses. Reflects state before the edge, with no internal bypass.
- `epc_out` = EPC register, so an `mtc0` EPC is visible the cycle after it is written.

## Timing
- `req` is combinational in the same cycle as the offending M-stage inputs. State updates on the following rising edge.
- Reset (asynchronous):
  - SR = 0, Cause = 0, EPC = 0.
  - Outputs: `req` = 0, `epc_out` = 0, `cp0_rdata` = 0 except addr 15, which returns `PRID_VAL`.
- Reset asserted mid-cycle with `req` high: the update is discarded and `req` drops immediately.
- While EXL = 1, `req` stays 0 even if `hw_int` or `exc_code_in` is active. A pending interrupt fires on the first cycle after EXL clears, provided IE & IM still permit it.
- `hw_int` may change on any edge. An interrupt deasserted before an enabling cycle is lost, with no latching.

## Structure
- Shared package `cp0_pkg`:
  - register numbers: `CP0_SR` = 12, `CP0_CAUSE` = 13, `CP0_EPC` = 14, `CP0_PRID` = 15.
  - bit-field positions.
  - ExcCode constants: `EXC_INT` 0, `EXC_ADEL` 4, `EXC_ADES` 5, `EXC_RI` 10, `EXC_OV` 12.
  - `HANDLER_PC` default.
- Single flat module; no sub-module.

## Test plan
- **Reset:** assert `reset` mid-cycle -> `req` = 0 and `epc_out` = 0 immediately; reading addr 15 returns 32'h4D49_5053; reading 12/13/14 returns 0.
- **Interrupt:** `mtc0` SR = 32'h0000_1401 (IM2, IE); raise `hw_int` = 6'b000100 with `vpc` = 0x3010, `bd_in` = 0.
  - Same cycle: `req` = 1.
  - Next cycle: EPC = 0x3010; Cause = 32'h0000_1000; SR = 32'h0000_1403.
- **Delay-slot exception:** `exc_code_in` = 12, `bd_in` = 1, `vpc` = 0x3024 -> EPC = 0x3020; Cause = 32'h8000_0030.
- **EXL masking and eret:** with EXL = 1 and `hw_int` held high, `req` stays 0.
  - Handler performs `mtc0` EPC = 0x3014; `epc_out` = 0x3014 the next cycle.
  - `exl_clr` clears EXL; `req` then rises the following cycle if `hw_int` is still high.
- **Priority:** on the same cycle, `hw_int` enabled, `exc_code_in` = 4 and `mtc0` SR = 0 -> ExcCode = 0, SR.EXL = 1, IE unchanged (write suppressed).
- **Read-only fields:** `mtc0` Cause = 32'hFFFF_FFFF and `mtc0` addr 7 -> Cause unchanged; addr 7 reads 0. `mtc0` SR = 32'hFFFF_FFFF -> SR reads 32'h0000_FC03.

Source files
------------

// File: rtl/cp0_pkg.sv
// cp0_pkg: register numbers, field positions and exception codes
// shared by the coprocessor-0 controller and its users.
package cp0_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int SR_IE     = 0;
    localparam int SR_EXL    = 1;
    localparam int IM_LO     = 10;
    localparam int IM_HI     = 15;
    localparam int CAUSE_BD  = 31;
    localparam int EXC_LO    = 2;
    localparam int EXC_HI    = 6;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

endpackage

// File: rtl/cp0.sv
// cp0: exception/interrupt arbitration for the M-stage instruction,
// plus SR/Cause/EPC/PRId state for mfc0/mtc0/eret.
module cp0
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VAL   = 32'h4D49_5053,
    parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic        exl_clr,
    input  logic [5:0]  hw_int,
    output logic        req,
    output logic [31:0] epc_out
);

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exc_code;
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic        w_req;
    logic [31:0] w_sr;
    logic [31:0] w_cause;
    logic [31:0] w_rdata;

    // Interrupts look at the live lines, not the latched IP copy.
    assign w_int_req = r_ie & ~r_exl & (|(hw_int & r_im));
    assign w_exc_req = ~r_exl & (exc_code_in != EXC_INT);
    assign w_req     = (w_int_req | w_exc_req) & ~reset;

    assign w_sr    = {16'b0, r_im, 8'b0, r_exl, r_ie};
    assign w_cause = {r_bd, 15'b0, r_ip, 3'b0, r_exc_code, 2'b0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_im       <= '0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ip       <= '0;
            r_exc_code <= '0;
            r_epc      <= '0;
        end else begin
            r_ip <= hw_int;
            if (w_req) begin
                r_exl      <= 1'b1;
                r_bd       <= bd_in;
                r_exc_code <= w_int_req ? EXC_INT : exc_code_in;
                r_epc      <= bd_in ? (vpc - 32'd4) : vpc;
            end else begin
                if (en && cp0_addr == CP0_SR) begin
                    r_im  <= cp0_wdata[IM_HI:IM_LO];
                    r_exl <= cp0_wdata[SR_EXL];
                    r_ie  <= cp0_wdata[SR_IE];
                end
                if (en && cp0_addr == CP0_EPC) begin
                    r_epc <= cp0_wdata;
                end
                // eret wins over a coincident SR write for EXL only.
                if (exl_clr) begin
                    r_exl <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        case (cp0_addr)
            CP0_SR:    w_rdata = w_sr;
            CP0_CAUSE: w_rdata = w_cause;
            CP0_EPC:   w_rdata = r_epc;
            CP0_PRID:  w_rdata = PRID_VAL;
            default:   w_rdata = '0;
        endcase
    end

    assign cp0_rdata = w_rdata;
    assign req       = w_req;
    assign epc_out   = r_epc;

endmodule

// File: tb/tb_cp0.sv
// tb_cp0: scoreboard bench for cp0; expectations are queued as stimulus
// is driven and drained against DUT outputs.
module tb_cp0;

    logic        clk;
    logic        reset;
    logic        en;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic        exl_clr;
    logic [5:0]  hw_int;
    logic        req;
    logic [31:0] epc_out;

    localparam int SEL_REQ = 32;
    localparam int SEL_EPC = 33;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_chk;
    int   n_fail;

    cp0 dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .cp0_addr    (cp0_addr),
        .cp0_wdata   (cp0_wdata),
        .cp0_rdata   (cp0_rdata),
        .vpc         (vpc),
        .bd_in       (bd_in),
        .exc_code_in (exc_code_in),
        .exl_clr     (exl_clr),
        .hw_int      (hw_int),
        .req         (req),
        .epc_out     (epc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h want %08h", tag, act, exp);
        end
    endtask

    task automatic expect_(input string tag, input int sel,
                           input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    // Pops every queued expectation; register reads steer cp0_addr.
    task automatic drain();
        exp_t        e;
        logic [4:0]  save;
        logic [31:0] act;
        save = cp0_addr;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel == SEL_REQ) begin
                #0.5;
                act = {31'b0, req};
            end else if (e.sel == SEL_EPC) begin
                #0.5;
                act = epc_out;
            end else begin
                cp0_addr = e.sel[4:0];
                #1;
                act = cp0_rdata;
            end
            chk(e.tag, act, e.val);
        end
        cp0_addr = save;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        en        = 1'b1;
        cp0_addr  = a;
        cp0_wdata = d;
        step();
        en        = 1'b0;
        cp0_addr  = 5'd0;
        cp0_wdata = '0;
    endtask

    task automatic eret();
        exl_clr = 1'b1;
        step();
        exl_clr = 1'b0;
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        reset       = 1'b1;
        en          = 1'b0;
        cp0_addr    = '0;
        cp0_wdata   = '0;
        vpc         = '0;
        bd_in       = 1'b0;
        exc_code_in = '0;
        exl_clr     = 1'b0;
        hw_int      = '0;

        step();
        step();
        expect_("rst_req",   SEL_REQ, 32'h0);
        expect_("rst_epc",   SEL_EPC, 32'h0);
        expect_("rst_prid",  15, 32'h4D49_5053);
        expect_("rst_sr",    12, 32'h0);
        expect_("rst_cause", 13, 32'h0);
        expect_("rst_epcr",  14, 32'h0);
        drain();
        step();
        reset = 1'b0;
        step();

        // Interrupt on IM2 with IE set.
        mtc0(5'd12, 32'h0000_1401);
        hw_int = 6'b000100;
        vpc    = 32'h0000_3010;
        bd_in  = 1'b0;
        expect_("int_req", SEL_REQ, 32'h1);
        drain();
        step();
        expect_("int_epc",   14, 32'h0000_3010);
        expect_("int_cause", 13, 32'h0000_1000);
        expect_("int_sr",    12, 32'h0000_1403);
        expect_("exl_mask",  SEL_REQ, 32'h0);
        drain();

        // Handler rewrites EPC; no bypass to epc_out this cycle.
        en        = 1'b1;
        cp0_addr  = 5'd14;
        cp0_wdata = 32'h0000_3014;
        expect_("epc_nobyp", SEL_EPC, 32'h0000_3010);
        drain();
        step();
        en = 1'b0;
        expect_("epc_mtc0",  SEL_EPC, 32'h0000_3014);
        expect_("exl_mask2", SEL_REQ, 32'h0);
        drain();

        // eret with interrupt still pending: fires on the next cycle.
        eret();
        vpc = 32'h0000_3014;
        expect_("eret_req", SEL_REQ, 32'h1);
        expect_("eret_sr",  12, 32'h0000_1401);
        drain();
        step();
        hw_int = '0;
        expect_("reint_sr",  12, 32'h0000_1403);
        expect_("reint_epc", SEL_EPC, 32'h0000_3014);
        drain();
        eret();

        // Overflow in a delay slot.
        exc_code_in = 5'd12;
        bd_in       = 1'b1;
        vpc         = 32'h0000_3024;
        expect_("ds_req", SEL_REQ, 32'h1);
        drain();
        step();
        exc_code_in = '0;
        bd_in       = 1'b0;
        expect_("ds_epc",   14, 32'h0000_3020);
        expect_("ds_cause", 13, 32'h8000_0030);
        expect_("ds_sr",    12, 32'h0000_1403);
        drain();
        eret();

        // Interrupt + exception + SR write on the same edge.
        hw_int      = 6'b000100;
        exc_code_in = 5'd4;
        vpc         = 32'h0000_3040;
        en          = 1'b1;
        cp0_addr    = 5'd12;
        cp0_wdata   = 32'h0;
        expect_("pri_req", SEL_REQ, 32'h1);
        drain();
        step();
        en          = 1'b0;
        cp0_addr    = 5'd0;
        hw_int      = '0;
        exc_code_in = '0;
        expect_("pri_cause", 13, 32'h0000_1000);
        expect_("pri_sr",    12, 32'h0000_1403);
        drain();

        // eret and SR write together: data lands, EXL forced low.
        exl_clr = 1'b1;
        mtc0(5'd12, 32'h0000_0403);
        exl_clr = 1'b0;
        expect_("clr_wr_sr", 12, 32'h0000_0401);
        drain();

        // Read-only / unmapped writes.
        mtc0(5'd13, 32'hFFFF_FFFF);
        mtc0(5'd7,  32'hFFFF_FFFF);
        mtc0(5'd15, 32'hFFFF_FFFF);
        expect_("ro_cause", 13, 32'h0);
        expect_("ro_addr7", 7,  32'h0);
        expect_("ro_prid",  15, 32'h4D49_5053);
        drain();
        mtc0(5'd12, 32'hFFFF_FFFF);
        expect_("sr_mask", 12, 32'h0000_FC03);
        drain();

        // EPC wraps below zero for a delay-slot fault at vpc 2.
        eret();
        exc_code_in = 5'd5;
        bd_in       = 1'b1;
        vpc         = 32'h0000_0002;
        expect_("wrap_req", SEL_REQ, 32'h1);
        drain();
        step();
        exc_code_in = '0;
        bd_in       = 1'b0;
        expect_("wrap_epc",   SEL_EPC, 32'hFFFF_FFFE);
        expect_("wrap_cause", 13, 32'h8000_0014);
        drain();

        // Reset mid-cycle while req is high.
        eret();
        hw_int = 6'b000001;
        expect_("pre_rst_req", SEL_REQ, 32'h1);
        drain();
        #1;
        reset = 1'b1;
        expect_("mid_rst_req", SEL_REQ, 32'h0);
        expect_("mid_rst_epc", SEL_EPC, 32'h0);
        expect_("mid_rst_sr",  12, 32'h0);
        drain();
        hw_int = '0;
        step();
        expect_("post_rst_cause", 13, 32'h0);
        expect_("post_rst_epc",   14, 32'h0);
        drain();
        reset = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
